// File: rtl/ef_adc12_pkg.sv
// Shared types and constants for the 12-bit SAR ADC sequencer.
package ef_adc12_pkg;

  localparam int unsigned ADC_WIDTH = 12;

  localparam int unsigned CFG_SEL_LO = 0;
  localparam int unsigned CFG_SEL_HI = 1;
  localparam int unsigned CFG_CONT   = 2;
  localparam int unsigned CFG_INV    = 3;

  typedef enum logic [2:0] {
    IDLE,
    RSTDAC,
    SAMPLE,
    CONVERT,
    DONE
  } adc_state_e;

  // Track-phase length in cycles: 2, 4, 8 or 16.
  function automatic logic [4:0] sample_len(input logic [1:0] sel);
    return 5'd2 << sel;
  endfunction

endpackage

// File: rtl/ef_adc12_sar_ctrl.sv
// SAR sequencer: resets the DAC, tracks the input, then binary-searches the
// code bit by bit against the comparator and publishes it with a VALID strobe.
module ef_adc12_sar_ctrl
  import ef_adc12_pkg::*;
#(
  parameter int unsigned WIDTH         = ADC_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             UserCLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       ConfigBits,
  input  logic             CMP_top,
  output logic             HOLD_top,
  output logic             RESET_top,
  output logic [WIDTH-1:0] VALUE_top,
  output logic [WIDTH-1:0] VALUE,
  output logic             VALID,
  output logic             BUSY
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  adc_state_e      state;
  logic [3:0]      cfg;
  logic [3:0]      cnt;
  logic [BW-1:0]   bit_idx;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] kept;
  logic            cmp_c;

  // VALUE_top doubles as the SAR register: it always holds the kept bits
  // plus the bit currently on trial.
  always_comb begin
    bit_mask = '0;
    bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << bit_idx;
    cmp_c    = CMP_top ^ cfg[CFG_INV];
    kept     = cmp_c ? (VALUE_top & ~bit_mask) : VALUE_top;
  end

  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      state     <= IDLE;
      cfg       <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      HOLD_top  <= 1'b0;
      RESET_top <= 1'b1;
      VALUE_top <= '0;
      VALUE     <= '0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      VALID     <= 1'b0;
      RESET_top <= 1'b0;
      case (state)
        IDLE: begin
          HOLD_top  <= 1'b0;
          VALUE_top <= '0;
          if (START) begin
            state     <= RSTDAC;
            cfg       <= ConfigBits;
            RESET_top <= 1'b1;
            BUSY      <= 1'b1;
          end else begin
            BUSY <= 1'b0;
          end
        end
        RSTDAC: begin
          state <= SAMPLE;
          cnt   <= 4'(sample_len(cfg[CFG_SEL_HI:CFG_SEL_LO]) - 5'd1);
        end
        SAMPLE: begin
          if (cnt == '0) begin
            state     <= CONVERT;
            HOLD_top  <= 1'b1;
            VALUE_top <= MSB;
            bit_idx   <= BW'(WIDTH - 1);
            cnt       <= SETTLE_INIT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CONVERT: begin
          if (cnt == '0) begin
            if (bit_idx == '0) begin
              state     <= DONE;
              VALUE     <= kept;
              VALID     <= 1'b1;
              HOLD_top  <= 1'b0;
              VALUE_top <= '0;
            end else begin
              VALUE_top <= kept | (bit_mask >> 1);
              bit_idx   <= bit_idx - 1'b1;
              cnt       <= SETTLE_INIT;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (cfg[CFG_CONT] && START) begin
            state     <= RSTDAC;
            cfg       <= ConfigBits;
            RESET_top <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          HOLD_top  <= 1'b0;
          VALUE_top <= '0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ef_adc12_sar_ctrl.sv
// Directed bench for the SAR sequencer with an ideal comparator model.
module tb_ef_adc12_sar_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic        START;
  logic [3:0]  ConfigBits;
  logic        CMP_top;
  logic        HOLD_top;
  logic        RESET_top;
  logic [11:0] VALUE_top;
  logic [11:0] VALUE;
  logic        VALID;
  logic        BUSY;

  logic [11:0] vin;
  logic        inv_model;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb CMP_top = (VALUE_top > vin) ^ inv_model;

  ef_adc12_sar_ctrl #(.WIDTH(12), .SETTLE_CYCLES(1)) dut (
    .UserCLK    (clk),
    .RESET      (RESET),
    .START      (START),
    .ConfigBits (ConfigBits),
    .CMP_top    (CMP_top),
    .HOLD_top   (HOLD_top),
    .RESET_top  (RESET_top),
    .VALUE_top  (VALUE_top),
    .VALUE      (VALUE),
    .VALID      (VALID),
    .BUSY       (BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called on the first negedge after START was captured (n0 = 0 there).
  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!VALID && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Drive a one-cycle START pulse; returns on the negedge after capture.
  task automatic kick(input logic [11:0] v, input logic [3:0] cfg, input logic inv);
    @(negedge clk);
    vin        = v;
    inv_model  = inv;
    ConfigBits = cfg;
    START      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    START = 1'b0;
  endtask

  task automatic single(input string tag, input logic [11:0] v, input logic [3:0] cfg,
                        input logic inv, input int lat);
    int n;
    kick(v, cfg, inv);
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    wait_valid(0, n);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_value"}, 32'(VALUE), 32'(v));
    @(negedge clk);
    chk({tag, "_valid_off"}, 32'(VALID), 32'd0);
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int n;
    int nvalid;
    RESET = 1'b1; START = 1'b0; ConfigBits = 4'b0000; vin = '0; inv_model = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_value",    32'(VALUE),     32'd0);
    chk("rst_valid",    32'(VALID),     32'd0);
    chk("rst_busy",     32'(BUSY),      32'd0);
    chk("rst_hold",     32'(HOLD_top),  32'd0);
    chk("rst_resettop", 32'(RESET_top), 32'd1);
    chk("rst_vtop",     32'(VALUE_top), 32'd0);
    RESET = 1'b0;
    @(negedge clk);
    chk("idle_resettop", 32'(RESET_top), 32'd0);

    single("a5c", 12'hA5C, 4'b0000, 1'b0, 27);
    single("zero", 12'h000, 4'b0000, 1'b0, 27);
    single("full", 12'hFFF, 4'b0000, 1'b0, 27);
    single("inv", 12'h3B7, 4'b1000, 1'b1, 27);
    single("sel1", 12'h801, 4'b0001, 1'b0, 29);

    // Back-to-back continuous conversions with START held high.
    @(negedge clk);
    vin = 12'h123; inv_model = 1'b0; ConfigBits = 4'b0111; START = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_valid(0, n);
    chk("b2b_lat1", 32'(n), 32'd41);
    chk("b2b_val1", 32'(VALUE), 32'h123);
    vin = 12'h456;
    @(negedge clk);
    chk("b2b_rstpulse", 32'(RESET_top), 32'd1);
    chk("b2b_vtop0",    32'(VALUE_top), 32'd0);
    chk("b2b_busy",     32'(BUSY),      32'd1);
    START = 1'b0;
    wait_valid(1, n);
    chk("b2b_lat2", 32'(n), 32'd42);
    chk("b2b_val2", 32'(VALUE), 32'h456);
    @(negedge clk);
    chk("b2b_idle", 32'(BUSY), 32'd0);

    // Reset during bit 5 of CONVERT.
    kick(12'h5A5, 4'b0000, 1'b0);
    n = 0;
    while (n < 15) begin
      @(negedge clk);
      n++;
    end
    chk("mid_vtop_bit5", 32'(VALUE_top), 32'h5A0);
    chk("mid_hold",      32'(HOLD_top),  32'd1);
    RESET = 1'b1;
    @(negedge clk);
    chk("mrst_value",    32'(VALUE),     32'd0);
    chk("mrst_valid",    32'(VALID),     32'd0);
    chk("mrst_hold",     32'(HOLD_top),  32'd0);
    chk("mrst_resettop", 32'(RESET_top), 32'd1);
    chk("mrst_busy",     32'(BUSY),      32'd0);
    RESET = 1'b0;
    @(negedge clk);
    single("after_rst", 12'h3C7, 4'b0000, 1'b0, 27);

    // START re-pulsed during CONVERT is ignored.
    kick(12'h7E1, 4'b0000, 1'b0);
    n = 0;
    while (!VALID && n < 200) begin
      START = (n == 10);
      @(negedge clk);
      n++;
    end
    START = 1'b0;
    chk("repulse_lat",   32'(n),     32'd27);
    chk("repulse_value", 32'(VALUE), 32'h7E1);
    nvalid = 0;
    repeat (60) begin
      @(negedge clk);
      if (VALID) nvalid++;
    end
    chk("repulse_single_valid", 32'(nvalid), 32'd0);

    // ConfigBits changed mid-conversion has no effect.
    kick(12'h9C3, 4'b0000, 1'b0);
    n = 0;
    while (n < 5) begin
      @(negedge clk);
      n++;
    end
    ConfigBits = 4'b1111;
    wait_valid(n, n);
    chk("cfgchg_lat",   32'(n),     32'd27);
    chk("cfgchg_value", 32'(VALUE), 32'h9C3);
    @(negedge clk);
    chk("cfgchg_idle", 32'(BUSY), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
